// File: rtl/sync_timing_pkg.sv
// Shared types and helpers for the raster timing generator.
package sync_timing_pkg;

    // Phase order within one axis period, starting at count 0.
    typedef enum logic [1:0] {
        PH_SYNC,
        PH_BP,
        PH_ACT,
        PH_FP
    } phase_e;

    // Full axis period: sync + back porch + active + front porch.
    function automatic int unsigned axis_total(input int unsigned sync,
                                               input int unsigned bp,
                                               input int unsigned act,
                                               input int unsigned fp);
        return sync + bp + act + fp;
    endfunction

    // First count value of the active region.
    function automatic int unsigned act_start(input int unsigned sync,
                                              input int unsigned bp);
        return sync + bp;
    endfunction

endpackage

// File: rtl/sync_timing_gen_axis.sv
// One timing axis: a wrapping counter plus its SYNC/BP/ACT/FP phase FSM.
// Both the counter and the phase advance only when step is high.
module timing_axis
    import sync_timing_pkg::*;
#(
    parameter int unsigned SYNC = 1,
    parameter int unsigned BP   = 1,
    parameter int unsigned ACT  = 1,
    parameter int unsigned FP   = 1,
    parameter int unsigned CW   = $clog2(axis_total(SYNC, BP, ACT, FP))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    output logic [CW-1:0] count,
    output phase_e        phase,
    output logic          wrap
);

    localparam int unsigned   TOTAL    = axis_total(SYNC, BP, ACT, FP);
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC - 1);
    localparam logic [CW-1:0] BP_END   = CW'(act_start(SYNC, BP) - 1);
    localparam logic [CW-1:0] ACT_END  = CW'(act_start(SYNC, BP) + ACT - 1);
    localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);

    logic [CW-1:0] count_nx;
    phase_e        phase_nx;

    // State register: counter and phase, async reset to the first sync count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= PH_SYNC;
        end else begin
            count <= count_nx;
            phase <= phase_nx;
        end
    end

    // Next state: phase moves on when the counter sits on its last value.
    always_comb begin
        count_nx = count;
        phase_nx = phase;
        if (step) begin
            count_nx = (count == LAST) ? '0 : count + CW'(1);
            case (phase)
                PH_SYNC: if (count == SYNC_END) phase_nx = PH_BP;
                PH_BP:   if (count == BP_END)   phase_nx = PH_ACT;
                PH_ACT:  if (count == ACT_END)  phase_nx = PH_FP;
                PH_FP:   if (count == LAST)     phase_nx = PH_SYNC;
                default:                        phase_nx = PH_SYNC;
            endcase
        end
    end

    // Output decode: wrap marks the step that returns the counter to 0.
    always_comb begin
        wrap = step && (count == LAST);
    end

endmodule

// File: rtl/sync_timing_gen.sv
// Raster timing generator: registered HSYNC/VSYNC/DE, pixel/line indices and
// line/frame start pulses, derived from cascaded horizontal/vertical axes.
module sync_timing_gen
    import sync_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int unsigned V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned H_X0    = act_start(H_SYNC, H_BP);
    localparam int unsigned V_Y0    = act_start(V_SYNC, V_BP);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("sync_timing_gen: every sync/porch/active length must be >= 1");
    end
    if ((2 ** X_W) < H_ACTIVE || (2 ** Y_W) < V_ACTIVE) begin : g_bad_width
        $error("sync_timing_gen: X_W/Y_W too narrow for the active area");
    end

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    phase_e        hphase;
    phase_e        vphase;
    logic          hwrap;
    logic          vstep;
    logic          vwrap_unused;  // end-of-frame strobe, not needed here
    logic          act_now;

    timing_axis #(
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .ACT  (H_ACTIVE),
        .FP   (H_FP),
        .CW   (HW)
    ) u_h (
        .clk   (clk),
        .rst   (rst),
        .step  (en),
        .count (hcnt),
        .phase (hphase),
        .wrap  (hwrap)
    );

    timing_axis #(
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .ACT  (V_ACTIVE),
        .FP   (V_FP),
        .CW   (VW)
    ) u_v (
        .clk   (clk),
        .rst   (rst),
        .step  (vstep),
        .count (vcnt),
        .phase (vphase),
        .wrap  (vwrap_unused)
    );

    // Vertical axis steps once per line, on the horizontal wrap.
    always_comb begin
        vstep   = en & hwrap;
        act_now = (hphase == PH_ACT) && (vphase == PH_ACT);
    end

    // Output registers: decode of the current counters, one en-cycle late.
    // Pulses clear on every edge so they never outlive a single en cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                hsync       <= (hphase == PH_SYNC);
                vsync       <= (vphase == PH_SYNC);
                de          <= act_now;
                x           <= act_now ? X_W'(hcnt - HW'(H_X0)) : '0;
                if (act_now) begin
                    y <= Y_W'(vcnt - VW'(V_Y0));
                end
                line_start  <= (hcnt == '0);
                frame_start <= (hcnt == '0) && (vcnt == '0);
            end
        end
    end

endmodule

// File: tb/tb_sync_timing_gen.sv
// Self-checking bench for sync_timing_gen (small raster: 8 clocks x 6 lines).
module tb_sync_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       hsync, vsync, de, line_start, frame_start;
    logic [1:0] x;
    logic [1:0] y;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raster position and expected outputs.
    int mh, mv;
    int e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs;

    sync_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .X_W (2), .Y_W (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0;
        e_hs = 0; e_vs = 0; e_de = 0; e_x = 0; e_y = 0; e_ls = 0; e_fs = 0;
    endtask

    // Expected outputs after one clock edge with the given enable.
    task automatic model_edge(input bit e);
        bit hact, vact;
        e_ls = 0;
        e_fs = 0;
        if (e) begin
            hact = (mh >= HS + HB) && (mh < HS + HB + HA);
            vact = (mv >= VS + VB) && (mv < VS + VB + VA);
            e_hs = (mh < HS);
            e_vs = (mv < VS);
            e_de = hact && vact;
            e_x  = e_de ? mh - (HS + HB) : 0;
            if (e_de) e_y = mv - (VS + VB);
            e_ls = (mh == 0);
            e_fs = (mh == 0) && (mv == 0);
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
    endtask

    task automatic compare_all();
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("de", de, e_de);
        chk("x", x, e_x);
        chk("y", y, e_y);
        chk("line_start", line_start, e_ls);
        chk("frame_start", frame_start, e_fs);
    endtask

    // One clock with enable e; outputs sampled 1 time unit after the edge.
    task automatic cyc(input bit e);
        en = e;
        @(posedge clk);
        #1;
        model_edge(e);
        compare_all();
    endtask

    initial begin
        int fs1, fs2, decnt, ymax, l0_hs, l0_de;

        rst = 1'b1;
        en  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Two full frames with en held high.
        fs1 = -1; fs2 = -1; decnt = 0; ymax = 0; l0_hs = 0; l0_de = 0;
        for (int i = 0; i < 2 * HT * VT + 4; i++) begin
            cyc(1'b1);
            if (i == 0) begin
                chk("first_hsync", hsync, 1);
                chk("first_vsync", vsync, 1);
                chk("first_line_start", line_start, 1);
                chk("first_frame_start", frame_start, 1);
                chk("first_de", de, 0);
            end
            if (i < HT) begin
                l0_hs += int'(hsync);
                l0_de += int'(de);
            end
            if (frame_start) begin
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
            if (fs1 >= 0 && fs2 < 0 && de) decnt++;
            if (int'(y) > ymax) ymax = int'(y);
        end
        chk("line0_hsync_cycles", l0_hs, HS);
        chk("line0_de_cycles", l0_de, 0);
        chk("frame_period", fs2 - fs1, HT * VT);
        chk("de_per_frame", decnt, HA * VA);
        chk("y_max", ymax, VA - 1);

        // Enable alternating every cycle.
        for (int i = 0; i < 120; i++) cyc(i % 2 == 0);

        // Random enable with occasional asynchronous reset pulses.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            cyc($urandom_range(0, 3) != 0);
        end

        // Reset in the middle of a frame at hcnt=5, vcnt=3.
        for (int i = 0; i < 2 * HT * VT && !(mh == 5 && mv == 3); i++) cyc(1'b1);
        chk("reach_h5_v3", int'(mh == 5 && mv == 3), 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_hsync", hsync, 0);
        chk("async_rst_de", de, 0);
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1);
        chk("post_rst_frame_start", frame_start, 1);
        for (int i = 0; i < HT * VT; i++) cyc(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
